alu4_cmd_driver: RTL and testbench

Sequencer that sits in front of the 4-bit ALU and drives its operand and select inputs. It accepts operation commands from a host through a valid/ready handshake and buffers them in a small FIFO. It issues one command at a time to the ALU, captures the ALU result into an internal accumulator, and returns result and flags on a valid/ready response channel. Each command's A operand is the current accumulator, so results chain from one command to the next.

---
 rtl/alu4_cmd_driver.sv | 144 ++++++++++++++
 tb/tb_alu4_cmd_driver.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu4_cmd_driver.sv
// Command sequencer for the 4-bit ALU: FIFO-buffered host commands,
// one-at-a-time issue, accumulator chaining and a valid/ready response.
module alu4_cmd_driver #(
    parameter int                DATA_W     = 4,
    parameter int                FIFO_DEPTH = 4,
    parameter logic [DATA_W-1:0] ACC_INIT   = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_imm,
    input  logic              cmd_load,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_sel,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_carry,
    input  logic              alu_zero,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_carry,
    output logic              rsp_zero,
    output logic [DATA_W-1:0] acc,
    output logic              busy
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } state_t;

    state_t state;

    logic [2:0]        op_mem  [FIFO_DEPTH];
    logic [DATA_W-1:0] imm_mem [FIFO_DEPTH];
    logic              ld_mem  [FIFO_DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic full;
    logic empty;
    logic push;
    logic pop;
    logic load_q;

    assign full      = (count == CNT_W'(FIFO_DEPTH));
    assign empty     = (count == '0);
    assign cmd_ready = !full;
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state == IDLE) && !empty;
    assign busy      = (state != IDLE);

    // Pointers wrap for free because the depth is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                op_mem[i]  <= '0;
                imm_mem[i] <= '0;
                ld_mem[i]  <= 1'b0;
            end
        end else begin
            if (push) begin
                op_mem[wr_ptr]  <= cmd_op;
                imm_mem[wr_ptr] <= cmd_imm;
                ld_mem[wr_ptr]  <= cmd_load;
                wr_ptr          <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= ACC_INIT;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_sel   <= '0;
            load_q    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_carry <= 1'b0;
            rsp_zero  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        alu_a   <= acc;
                        alu_b   <= imm_mem[rd_ptr];
                        alu_sel <= op_mem[rd_ptr];
                        load_q  <= ld_mem[rd_ptr];
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    // alu_b still holds the immediate, so a load reads it back.
                    if (load_q) begin
                        acc       <= alu_b;
                        rsp_data  <= alu_b;
                        rsp_zero  <= (alu_b == '0);
                        rsp_carry <= 1'b0;
                    end else begin
                        acc       <= alu_out;
                        rsp_data  <= alu_out;
                        rsp_zero  <= alu_zero;
                        rsp_carry <= (alu_sel == 3'b000) ? alu_carry : 1'b0;
                    end
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu4_cmd_driver.sv
// Directed bench for alu4_cmd_driver with a behavioural 4-bit ALU attached.
module tb_alu4_cmd_driver;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [3:0] cmd_imm;
    logic       cmd_load;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [2:0] alu_sel;
    logic [3:0] alu_out;
    logic       alu_carry;
    logic       alu_zero;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rsp_data;
    logic       rsp_carry;
    logic       rsp_zero;
    logic [3:0] acc;
    logic       busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu4_cmd_driver dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_imm   (cmd_imm),
        .cmd_load  (cmd_load),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_sel   (alu_sel),
        .alu_out   (alu_out),
        .alu_carry (alu_carry),
        .alu_zero  (alu_zero),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_carry (rsp_carry),
        .rsp_zero  (rsp_zero),
        .acc       (acc),
        .busy      (busy)
    );

    // ALU carry is driven for sub/inc/dec too, so the driver must mask it.
    logic [4:0] alu_tmp;
    always_comb begin
        alu_tmp = '0;
        case (alu_sel)
            3'b000: alu_tmp = {1'b0, alu_a} + {1'b0, alu_b};
            3'b001: alu_tmp = {1'b0, alu_a} - {1'b0, alu_b};
            3'b010: alu_tmp = {1'b0, alu_a & alu_b};
            3'b011: alu_tmp = {1'b0, alu_a | alu_b};
            3'b100: alu_tmp = {1'b0, alu_a ^ alu_b};
            3'b101: alu_tmp = {1'b0, ~alu_a};
            3'b110: alu_tmp = {1'b0, alu_a} + 5'd1;
            default: alu_tmp = {1'b0, alu_a} - 5'd1;
        endcase
        alu_out   = alu_tmp[3:0];
        alu_carry = alu_tmp[4];
        alu_zero  = (alu_tmp[3:0] == 4'd0);
    end

    typedef struct {
        logic       ld;
        logic [2:0] op;
        logic [3:0] imm;
        logic [3:0] data;
        logic       c;
        logic       z;
    } vec_t;

    vec_t vecs[14];

    task automatic chk1(string name, logic act, logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0b want=%0b", name, act, exp);
        end
    endtask

    task automatic chk4(string name, logic [3:0] act, logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(vec_t v, int i);
        chk1($sformatf("v%0d_cmd_ready", i), cmd_ready, 1'b1);
        cmd_valid = 1'b1;
        cmd_load  = v.ld;
        cmd_op    = v.op;
        cmd_imm   = v.imm;
        tick();
        cmd_valid = 1'b0;
        chk1($sformatf("v%0d_lat0", i), rsp_valid, 1'b0);
        tick();
        chk1($sformatf("v%0d_lat1", i), rsp_valid, 1'b0);
        chk1($sformatf("v%0d_busy", i), busy, 1'b1);
        chk4($sformatf("v%0d_alu_b", i), alu_b, v.imm);
        chk4($sformatf("v%0d_alu_sel", i), {1'b0, alu_sel}, {1'b0, v.op});
        tick();
        chk1($sformatf("v%0d_lat2", i), rsp_valid, 1'b1);
        chk4($sformatf("v%0d_data", i), rsp_data, v.data);
        chk1($sformatf("v%0d_carry", i), rsp_carry, v.c);
        chk1($sformatf("v%0d_zero", i), rsp_zero, v.z);
        chk4($sformatf("v%0d_acc", i), acc, v.data);
        tick();
        chk1($sformatf("v%0d_hold_valid", i), rsp_valid, 1'b1);
        chk4($sformatf("v%0d_hold_data", i), rsp_data, v.data);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk1($sformatf("v%0d_drop", i), rsp_valid, 1'b0);
        chk1($sformatf("v%0d_idle", i), busy, 1'b0);
    endtask

    task automatic wait_rsp(output logic ok);
        int n = 0;
        while (!rsp_valid && n < 20) begin
            tick();
            n++;
        end
        ok = rsp_valid;
    endtask

    initial begin
        logic ok;
        logic seen;
        vec_t v9;

        vecs[0]  = '{1'b1, 3'b000, 4'h5, 4'h5, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 3'b000, 4'h3, 4'h8, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 3'b000, 4'h9, 4'h1, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 3'b001, 4'h1, 4'h0, 1'b0, 1'b1};
        vecs[4]  = '{1'b1, 3'b000, 4'hF, 4'hF, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 3'b110, 4'h0, 4'h0, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, 3'b111, 4'h0, 4'hF, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 3'b000, 4'hA, 4'hA, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 3'b010, 4'h6, 4'h2, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 3'b011, 4'h5, 4'h7, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 3'b100, 4'hF, 4'h8, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 3'b101, 4'h0, 4'h7, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 3'b001, 4'h9, 4'hE, 1'b0, 1'b0};
        vecs[13] = '{1'b1, 3'b000, 4'h0, 4'h0, 1'b0, 1'b1};
        v9       = '{1'b1, 3'b000, 4'h9, 4'h9, 1'b0, 1'b0};

        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_imm   = '0;
        cmd_load  = 1'b0;
        rsp_ready = 1'b0;
        repeat (3) tick();
        chk1("rst_cmd_ready", cmd_ready, 1'b1);
        chk1("rst_rsp_valid", rsp_valid, 1'b0);
        chk4("rst_rsp_data", rsp_data, 4'h0);
        chk1("rst_rsp_carry", rsp_carry, 1'b0);
        chk1("rst_rsp_zero", rsp_zero, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk4("rst_acc", acc, 4'h0);
        chk4("rst_alu_a", alu_a, 4'h0);
        chk4("rst_alu_b", alu_b, 4'h0);
        chk4("rst_alu_sel", {1'b0, alu_sel}, 4'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 14; i++) run_vec(vecs[i], i);

        // Backpressure: first command parks in RESP, four more fill the FIFO.
        for (int i = 0; i < 6; i++) begin
            cmd_valid = 1'b1;
            cmd_load  = (i == 0);
            cmd_op    = 3'b000;
            cmd_imm   = 4'h1;
            chk1($sformatf("bp_ready%0d", i), cmd_ready, i < 5);
            tick();
        end
        cmd_valid = 1'b0;
        repeat (3) tick();
        chk1("bp_valid", rsp_valid, 1'b1);
        chk4("bp_stall_data", rsp_data, 4'h1);
        chk4("bp_stall_acc", acc, 4'h1);
        chk1("bp_full", cmd_ready, 1'b0);
        chk1("bp_busy", busy, 1'b1);
        for (int j = 0; j < 5; j++) begin
            wait_rsp(ok);
            chk1($sformatf("bp_rsp%0d_timeout", j), ok, 1'b1);
            chk4($sformatf("bp_rsp%0d_data", j), rsp_data, 4'(j + 1));
            rsp_ready = 1'b1;
            tick();
            rsp_ready = 1'b0;
        end
        repeat (4) tick();
        chk1("bp_no_sixth", rsp_valid, 1'b0);
        chk4("bp_acc_end", acc, 4'h5);
        chk1("bp_ready_back", cmd_ready, 1'b1);
        chk1("bp_idle", busy, 1'b0);

        // Reset while a command is in ISSUE and two more are queued.
        for (int i = 0; i < 4; i++) begin
            cmd_valid = 1'b1;
            cmd_load  = (i == 0);
            cmd_op    = 3'b000;
            cmd_imm   = (i == 0) ? 4'h3 : 4'h1;
            tick();
        end
        cmd_valid = 1'b0;
        chk1("mr_resp1", rsp_valid, 1'b1);
        chk4("mr_resp1_data", rsp_data, 4'h3);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        tick();
        chk1("mr_issue_busy", busy, 1'b1);
        chk1("mr_issue_valid", rsp_valid, 1'b0);
        chk4("mr_issue_alu_a", alu_a, 4'h3);
        rst_n = 1'b0;
        #1;
        chk1("mr_busy", busy, 1'b0);
        chk4("mr_acc", acc, 4'h0);
        chk1("mr_cmd_ready", cmd_ready, 1'b1);
        chk4("mr_alu_a", alu_a, 4'h0);
        chk4("mr_alu_b", alu_b, 4'h0);
        chk4("mr_alu_sel", {1'b0, alu_sel}, 4'h0);
        chk4("mr_rsp_data", rsp_data, 4'h0);
        repeat (2) tick();
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (rsp_valid || busy) seen = 1'b1;
        end
        chk1("mr_no_stale", seen, 1'b0);
        chk4("mr_acc_after", acc, 4'h0);
        chk1("mr_ready_after", cmd_ready, 1'b1);
        run_vec(v9, 99);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
